// File: rtl/dds_axis_pkg.sv
// Shared definitions for the DDS sample-path AXI-Stream stages.
package dds_axis_pkg;

    // Default sample width: sign-extended DDS output word.
    localparam int DDS_DATA_W = 32;

    // Packetizer FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // True when a beat at position cnt is the final beat of a len-beat frame.
    // len is never zero while a frame is in progress.
    function automatic logic beat_is_last(input logic [15:0] cnt, input logic [15:0] len);
        return (cnt == (len - 16'd1));
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered output stage plus one skid
// register. Upstream ready depends only on registers, so there is no
// combinational path from out_ready back to in_ready.
module axis_skid_buffer #(
    parameter int W = 33
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_allow,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         empty
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         in_fire;
    logic         out_load;

    assign in_ready = in_allow & ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    // Output register may take a new beat when empty or being drained now.
    assign out_load = ~out_valid | out_ready;
    assign empty    = ~out_valid & ~skid_valid;

    // Output/skid register update; skid always drains first to keep ordering.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                // in_ready is low while skid is occupied, so no new beat here.
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // Output is held by downstream backpressure: park the beat.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_frame_packetizer.sv
// AXI-Stream framing stage: passes samples through unchanged and marks every
// len_q-th beat with TLAST. Software enable starts frames; dropping it lets
// the current frame finish and drain before returning to idle.
//
// state | meaning
// IDLE  | no frame open, upstream held off
// RUN   | accepting beats of the current frame
// FLUSH | final beat accepted, waiting for output stage to drain
module axis_frame_packetizer
    import dds_axis_pkg::*;
#(
    parameter int DATA_W = DDS_DATA_W,
    parameter int LEN_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic [31:0]       frame_count
);

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic             accept;
    logic             beat_last;
    logic             start_ok;
    logic             buf_empty;
    logic [DATA_W:0]  buf_out;

    assign accept    = s_axis_tvalid & s_axis_tready;
    // cnt never exceeds len_q-1, so it cannot wrap even at the maximum length.
    assign beat_last = (cnt == (len_q - LEN_ONE));
    assign start_ok  = enable & (frame_len != '0);
    assign busy      = (state == ST_RUN) | (state == ST_FLUSH);

    // Frame sequencing: length latch, beat counter and state transitions.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            len_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state <= ST_RUN;
                        len_q <= frame_len;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (beat_last) begin
                            cnt <= '0;
                            if (start_ok) begin
                                len_q <= frame_len;
                            end else begin
                                state <= ST_FLUSH;
                            end
                        end else begin
                            cnt <= cnt + LEN_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (buf_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completed frames are counted when the last beat leaves, not when it enters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_count <= '0;
        end else if (m_axis_tvalid & m_axis_tready & m_axis_tlast) begin
            frame_count <= frame_count + 32'd1;
        end
    end

    axis_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_allow  (state == ST_RUN),
        .in_data   ({beat_last, s_axis_tdata}),
        .in_valid  (s_axis_tvalid),
        .in_ready  (s_axis_tready),
        .out_data  (buf_out),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .empty     (buf_empty)
    );

    assign m_axis_tdata = buf_out[DATA_W-1:0];
    assign m_axis_tlast = buf_out[DATA_W];

endmodule

// File: tb/tb_axis_frame_packetizer.sv
module tb_axis_frame_packetizer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] frame_len = '0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic [31:0] frame_count;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int sink_mode = 0;   // 0 always ready, 1 toggle, 2 stalled
    logic [32:0] exp_q[$];

    axis_frame_packetizer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .frame_len     (frame_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Sink ready pattern, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (sink_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: pop and compare on each output handshake; check hold stability.
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat = '0;
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
                    check("hold_data", m_axis_tdata, prev_beat[31:0]);
                    check("hold_last", {31'd0, m_axis_tlast}, {31'd0, prev_beat[32]});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data 0x%08h last %0b, expected none",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        exp = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, exp[31:0]);
                        check("beat_last", {31'd0, m_axis_tlast}, {31'd0, exp[32]});
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = {m_axis_tlast, m_axis_tdata};
            end
        end
    end

    // Offer n beats base..base+n-1; lastmask bit i is the hand-computed tlast of beat i.
    task automatic send(input logic [31:0] base, input int n, input logic [63:0] lastmask,
                        input int drop_idx, input int chg_idx, input logic [15:0] chg_len,
                        input bit push);
        logic ok;
        int   waits;
        for (int i = 0; i < n; i++) begin
            if (i == drop_idx) enable = 1'b0;
            if (i == chg_idx) frame_len = chg_len;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = base + i;
            if (push) exp_q.push_back({lastmask[i], base + 32'(i)});
            waits = 0;
            do begin
                @(negedge aclk);
                ok = s_axis_tready;
                @(posedge aclk);
                #1;
                if (!ok) begin
                    waits++;
                    if (i > 0) stalls++;
                end
            end while (!ok && waits < 200);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: beat 0x%08h never accepted, expected accept", base + i);
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        #23;
        check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fcount", frame_count, 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        sink_mode = 0;
        repeat (2) @(posedge aclk);
        #1;

        // 1: len 4, data 0..11, full rate
        frame_len = 16'd4;
        enable = 1'b1;
        stalls = 0;
        send(32'd0, 12, 64'h888, 11, -1, 16'd0, 1'b1);
        check("t1_no_stalls", 32'(stalls), 32'd0);
        wait_idle("t1_idle");
        check("t1_fcount", frame_count, 32'd3);

        // 2: same framing, sink toggles ready
        sink_mode = 1;
        enable = 1'b1;
        stalls = 0;
        send(32'd100, 12, 64'h888, 11, -1, 16'd0, 1'b1);
        check("t2_skid_backpressure", {31'd0, stalls > 0}, 32'd1);
        wait_idle("t2_idle");
        check("t2_fcount", frame_count, 32'd6);
        sink_mode = 0;

        // 3: len 8, enable drops after beat 2 accepted
        frame_len = 16'd8;
        enable = 1'b1;
        send(32'd200, 8, 64'h80, 3, -1, 16'd0, 1'b1);
        wait_idle("t3_idle");
        check("t3_fcount", frame_count, 32'd7);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_0999;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("t3_held_tready", {31'd0, s_axis_tready}, 32'd0);
        end
        s_axis_tvalid = 1'b0;

        // 4: len 1, every beat last; then len 0 never starts
        frame_len = 16'd1;
        enable = 1'b1;
        send(32'd300, 5, 64'h1F, 4, -1, 16'd0, 1'b1);
        wait_idle("t4_idle");
        check("t4_fcount", frame_count, 32'd12);
        frame_len = 16'd0;
        enable = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("t4_len0_busy", {31'd0, busy}, 32'd0);
            check("t4_len0_tready", {31'd0, s_axis_tready}, 32'd0);
        end
        enable = 1'b0;
        s_axis_tvalid = 1'b0;

        // 5: len 4 -> 6 changed mid-frame takes effect on the next frame
        frame_len = 16'd4;
        enable = 1'b1;
        send(32'd400, 10, 64'h208, 9, 1, 16'd6, 1'b1);
        wait_idle("t5_idle");
        check("t5_fcount", frame_count, 32'd14);

        // 6: reset while stalled, then fresh len 3 frames
        sink_mode = 2;
        frame_len = 16'd3;
        enable = 1'b1;
        send(32'd500, 2, 64'h0, -1, -1, 16'd0, 1'b0);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        enable = 1'b0;
        #1;
        check("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("t6_rst_tdata", m_axis_tdata, 32'd0);
        check("t6_rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("t6_rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_fcount", frame_count, 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        sink_mode = 0;
        @(posedge aclk);
        #1;
        frame_len = 16'd3;
        enable = 1'b1;
        send(32'd600, 6, 64'h24, 5, -1, 16'd0, 1'b1);
        wait_idle("t6_idle");
        check("t6_fcount", frame_count, 32'd2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_frame_packetizer.md
Name: axis_frame_packetizer

Overview:
AXI-Stream framing stage between the sample FIFO and the DMA S2MM channel. It consumes the 32-bit sign-extended DDS sample stream and re-emits it unchanged, asserting TLAST on every frame_len-th beat. It is gated by a software enable, and always completes the frame in progress before stopping. A full-throughput, 2-entry skid buffer with registered outputs breaks the combinational ready/valid path between the FIFO and the DMA.

Parameters:
DATA_W, 32, stream data width in bits.
LEN_W, 16, width of the frame-length input and the beat counter.

Ports:
aclk  in  1  clock.
aresetn  in  1  asynchronous active-low reset.
enable  in  1  level; 1 = start and continue frames; 0 = stop after the current frame.
frame_len  in  LEN_W  beats per frame; sampled only at frame start.
s_axis_tdata  in  DATA_W  sample from FIFO.
s_axis_tvalid  in  1  upstream valid.
s_axis_tready  out  1  ready to upstream.
m_axis_tdata  out  DATA_W  sample to DMA.
m_axis_tvalid  out  1  downstream valid.
m_axis_tlast  out  1  final beat of a frame.
m_axis_tready  in  1  downstream ready.
busy  out  1  high in RUN or FLUSH.
frame_count  out  32  number of completed frames output since reset; wraps modulo 2^32.

Behaviour:
- Reset: async assert on aresetn low, synchronous release. All outputs are 0, state is IDLE, beat counter is 0, skid buffer is empty.
- Reset mid-operation: in-flight beats are discarded, frame_count clears, and no partial TLAST is issued.
- Accept condition: accept = s_axis_tvalid & s_axis_tready.
- s_axis_tready = (state==RUN) & ~skid_full. It is driven from registers only and has no combinational path from m_axis_tready.
- States:
  - IDLE: tready=0 (backpressure, no samples dropped). Go to RUN when enable=1 and frame_len!=0; on that transition len_q<=frame_len and cnt<=0. If frame_len==0 with enable=1, stay in IDLE.
  - RUN: on each accept, cnt increments and the beat is tagged last=(cnt==len_q-1).
    - On an accept tagged last: cnt<=0. If enable=1 and frame_len!=0, re-latch len_q<=frame_len and stay in RUN with no idle cycle. Otherwise go to FLUSH.
    - enable falling mid-frame has no effect until the last beat.
    - frame_len changes mid-frame are ignored.
  - FLUSH: tready=0. Go to IDLE once the output register and skid buffer are both empty, i.e. the last beat has been taken by the downstream.
- frame_count increments on the output handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast), not on input acceptance.
- Datapath:
  - tdata passes bit-exact, with no arithmetic and no width change; tlast travels alongside its beat.
  - Latency is 1 cycle from input accept to m_axis_tvalid when the output register is empty.
- Skid buffer (2 entries: output register + skid register):
  - Output register loads when empty or when the downstream handshake occurs this cycle.
  - If an accept arrives while the output register is held (m_axis_tvalid=1, m_axis_tready=0), the beat goes to the skid register; skid_full then drops tready next cycle.
  - When skid_full and the downstream handshakes, skid moves into the output register and the skid register empties.
  - Sustained throughput is 1 beat/cycle with both sides ready.
  - m_axis_tdata/tlast must be stable while m_axis_tvalid=1 and m_axis_tready=0.
- Boundaries:
  - frame_len=1: every beat carries tlast.
  - frame_len=2^LEN_W-1: the counter must not overflow.
  - An input accept and output handshake in the same cycle with skid_full=0 must not lose or duplicate a beat.
  - enable toggling inside FLUSH is ignored until IDLE is reached.

Decomposition:
- Shared package `dds_axis_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2) and the DATA_W default of 32, also used by the sample-path stages.
- One sub-module, `axis_skid_buffer` (parameterised by DATA_W+1 to carry tlast), owns the output and skid registers and the tready generation.
- The top level holds the FSM, the counter and frame_count.

Test Plan:
1. frame_len=4, enable=1, source always valid with data 0..11, sink always ready -> 12 beats out in order at 1/cycle, tlast on data 3, 7, 11; frame_count=3.
2. Same as 1 but sink ready toggles 1,0,1,0 -> no loss or duplication; data/tlast held stable while stalled; s_axis_tready drops only when the skid buffer fills.
3. frame_len=8, deassert enable after beat 2 is accepted -> beats 3..7 still accepted, tlast on beat 7, busy falls after the final handshake, then tready=0 and further input is held.
4. frame_len=1 -> every beat has tlast; frame_count equals the beat count. Then frame_len=0 with enable pulsed -> block stays in IDLE with tready=0.
5. Change frame_len 4->6 at beat 1 of a frame -> current frame ends at 4 beats, next frame ends at 6 beats.
6. Assert aresetn=0 mid-frame while the sink is stalled -> all outputs 0 immediately. After release with frame_len=3, first tlast occurs on the 3rd new beat.
